// File: rtl/conv_seq_engine.sv
// Time-multiplexed conv engine: one output channel per cycle through a shared dot-product lane.
// Build option CONV_SEQ_DUAL_LANE_EN: two lanes compute channels oc and oc+1 together (OUT_CH even).
module conv_seq_engine #(
    parameter int IN_CH  = 3,
    parameter int KTAPS  = 9,
    parameter int OUT_CH = 8,
    parameter int ACT_W  = 16,
    parameter int W_W    = 4,
    parameter int ACC_W  = 32,
    parameter int SHIFT  = 3,
    parameter int CLIP   = 6
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_CH*KTAPS*ACT_W-1:0]    input_act,
    input  logic                            cfg_we,
    input  logic [$clog2(OUT_CH)-1:0]       cfg_addr,
    input  logic [IN_CH*KTAPS*W_W-1:0]      cfg_wt,
    input  logic [ACT_W-1:0]                cfg_bias,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_CH*ACT_W-1:0]         output_act,
    output logic                            busy
);

    localparam int NT   = IN_CH * KTAPS;
    localparam int OC_W = $clog2(OUT_CH);
    localparam int PW   = ACT_W + W_W;
`ifdef CONV_SEQ_DUAL_LANE_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif

    // state   | meaning
    // IDLE    | accepting a window and config writes
    // COMPUTE | producing LANES result slots per cycle
    // DONE    | results held until the consumer accepts
    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [OC_W-1:0]         oc_q, oc_d;
    logic [NT*ACT_W-1:0]     act_q, act_d;
    logic [NT*W_W-1:0]       wt_q [OUT_CH];
    logic [NT*W_W-1:0]       wt_d [OUT_CH];
    logic [ACT_W-1:0]        bias_q [OUT_CH];
    logic [ACT_W-1:0]        bias_d [OUT_CH];
    logic [OUT_CH*ACT_W-1:0] res_q, res_d;
    logic [OC_W-1:0]         slot_idx;

    function automatic logic signed [ACC_W-1:0] dot(input logic [NT*W_W-1:0] w,
                                                    input logic [ACT_W-1:0] b,
                                                    input logic [NT*ACT_W-1:0] a);
        logic signed [ACC_W-1:0] acc;
        logic signed [PW-1:0]    p;
        acc = {{(ACC_W-ACT_W){b[ACT_W-1]}}, b};
        for (int i = 0; i < NT; i++) begin
            p   = PW'($signed(a[i*ACT_W +: ACT_W])) * PW'($signed(w[i*W_W +: W_W]));
            acc = acc + {{(ACC_W-PW){p[PW-1]}}, p};
        end
        return acc;
    endfunction

    function automatic logic [ACT_W-1:0] relu(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] s;
        logic [ACT_W-1:0]        r;
        s = acc >>> SHIFT;
        if (acc < 0)
            r = '0;
        else if (s > ACC_W'(CLIP))
            r = ACT_W'(CLIP);
        else
            r = s[ACT_W-1:0];
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        oc_d     = oc_q;
        act_d    = act_q;
        wt_d     = wt_q;
        bias_d   = bias_q;
        res_d    = res_q;
        slot_idx = '0;
        case (state_q)
            S_IDLE: begin
                // A write in the accept cycle lands before the first compute cycle reads it.
                if (cfg_we && (int'(cfg_addr) < OUT_CH)) begin
                    wt_d[cfg_addr]   = cfg_wt;
                    bias_d[cfg_addr] = cfg_bias;
                end
                if (in_valid) begin
                    act_d   = input_act;
                    oc_d    = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                for (int l = 0; l < LANES; l++) begin
                    slot_idx = oc_q + OC_W'(l);
                    res_d[slot_idx*ACT_W +: ACT_W] = relu(dot(wt_q[slot_idx], bias_q[slot_idx], act_q));
                end
                if (oc_q == OC_W'(OUT_CH - LANES))
                    state_d = S_DONE;
                else
                    oc_d = oc_q + OC_W'(LANES);
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            oc_q    <= '0;
            act_q   <= '0;
            res_q   <= '0;
            for (int o = 0; o < OUT_CH; o++) begin
                wt_q[o]   <= '0;
                bias_q[o] <= '0;
            end
        end else begin
            state_q <= state_d;
            oc_q    <= oc_d;
            act_q   <= act_d;
            res_q   <= res_d;
            wt_q    <= wt_d;
            bias_q  <= bias_d;
        end
    end

    assign in_ready   = rstn && (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign output_act = res_q;

endmodule
